// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Shared constants and types for the timer APB register block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TIER = 8'h03;
  localparam logic [7:0] ADDR_TCNT = 8'h04;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_EN      = 5;
  localparam int TCR_DIR     = 4;
  localparam int TCR_CKS_LSB = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  localparam int TIER_OVF_IE = 0;
  localparam int TIER_UDF_IE = 1;

  typedef enum logic [1:0] {
    CLK_2  = 2'b00,
    CLK_4  = 2'b01,
    CLK_8  = 2'b10,
    CLK_16 = 2'b11
  } cks_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Readback image of TCR: LOAD and reserved bits always read as zero.
  function automatic logic [7:0] tcr_pack(input logic en, input logic dir, input cks_e cks);
    logic [7:0] r;
    r = '0;
    r[TCR_EN]               = en;
    r[TCR_DIR]              = dir;
    r[TCR_CKS_LSB +: 2]     = cks;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_apb_regs_apb_fsm.sv
// ============================================================================
// Module : apb_fsm
// Brief  : APB completer handshake: pready, commit strobe, optional wait state
//          (enabled by TMR_WAIT_STATE_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_fsm
  import timer_pkg::*;
(
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic commit
);

`ifdef TMR_WAIT_STATE_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif

  apb_state_e state_q, state_d;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // state_q holds the phase reached at the last edge, so the access phase is
  // recognised combinationally and pready can rise in its first cycle.
  always_comb begin
    state_d = IDLE;
    pready  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = SETUP;
      end
      SETUP, ACCESS: begin
        if (psel && !penable) begin
          state_d = SETUP;
        end else if (psel && penable) begin
          pready  = !WAIT_EN || (state_q == ACCESS);
          commit  = pready;
          state_d = pready ? IDLE : ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/timer_apb_regs.sv
// ============================================================================
// Module : timer_apb_regs
// Brief  : Timer register block (TDR/TCR/TSR/TIER/TCNT) behind an APB completer.
//          Optional one-wait-state bus timing via TMR_WAIT_STATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        cnt_in,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              cnt_en_o,
  output logic              dir_o,
  output logic [1:0]        cks_o,
  output logic              irq_o
);

  logic       commit;
  logic       addr_err;
  logic       wr_en;
  logic [7:0] rd_data;
  logic [1:0] tsr_clr;
  logic [1:0] evt_vec;

  logic [7:0] tdr_q,  tdr_d;
  logic       en_q,   en_d;
  logic       dir_q,  dir_d;
  cks_e       cks_q,  cks_d;
  logic       load_q, load_d;
  logic [1:0] tsr_q,  tsr_d;
  logic [1:0] tier_q, tier_d;
  logic       irq_q,  irq_d;

  apb_fsm u_apb_fsm (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .commit  (commit)
  );

  always_comb begin
    addr_err = (paddr > ADDR_W'(ADDR_TCNT)) || (pwrite && (paddr == ADDR_W'(ADDR_TCNT)));
    wr_en    = commit && pwrite && !addr_err;

    rd_data = '0;
    case (paddr)
      ADDR_W'(ADDR_TDR):  rd_data = tdr_q;
      ADDR_W'(ADDR_TCR):  rd_data = tcr_pack(en_q, dir_q, cks_q);
      ADDR_W'(ADDR_TSR):  rd_data = {6'b0, tsr_q};
      ADDR_W'(ADDR_TIER): rd_data = {6'b0, tier_q};
      ADDR_W'(ADDR_TCNT): rd_data = cnt_in;
      default:            rd_data = '0;
    endcase

    prdata  = (pready && !pwrite && !addr_err) ? DATA_W'(rd_data) : '0;
    pslverr = pready && addr_err;
  end

  always_comb begin
    tdr_d   = tdr_q;
    en_d    = en_q;
    dir_d   = dir_q;
    cks_d   = cks_q;
    tier_d  = tier_q;
    load_d  = 1'b0;
    tsr_clr = '0;
    evt_vec = '0;

    if (wr_en) begin
      case (paddr)
        ADDR_W'(ADDR_TDR): tdr_d = pwdata[7:0];
        ADDR_W'(ADDR_TCR): begin
          en_d   = pwdata[TCR_EN];
          dir_d  = pwdata[TCR_DIR];
          cks_d  = cks_e'(pwdata[TCR_CKS_LSB +: 2]);
          load_d = pwdata[TCR_LOAD];
        end
        ADDR_W'(ADDR_TSR): begin
          tsr_clr[TSR_OVF] = pwdata[TSR_OVF];
          tsr_clr[TSR_UDF] = pwdata[TSR_UDF];
        end
        ADDR_W'(ADDR_TIER): begin
          tier_d[TIER_OVF_IE] = pwdata[TIER_OVF_IE];
          tier_d[TIER_UDF_IE] = pwdata[TIER_UDF_IE];
        end
        default: ;
      endcase
    end

    // A counter event in the same cycle as its W1C clear leaves the bit set.
    evt_vec[TSR_OVF] = ovf_evt;
    evt_vec[TSR_UDF] = udf_evt;
    tsr_d = (tsr_q & ~tsr_clr) | evt_vec;
    irq_d = |(tsr_q & tier_q);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      tdr_q  <= '0;
      en_q   <= 1'b0;
      dir_q  <= 1'b0;
      cks_q  <= CLK_2;
      load_q <= 1'b0;
      tsr_q  <= '0;
      tier_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      en_q   <= en_d;
      dir_q  <= dir_d;
      cks_q  <= cks_d;
      load_q <= load_d;
      tsr_q  <= tsr_d;
      tier_q <= tier_d;
      irq_q  <= irq_d;
    end
  end

  assign tdr_o    = tdr_q;
  assign load_o   = load_q;
  assign cnt_en_o = en_q;
  assign dir_o    = dir_q;
  assign cks_o    = cks_q;
  assign irq_o    = irq_q;

endmodule

`default_nettype wire
